vga_dac_ctrl: RTL and testbench

VGA_DAC_CTRL -- requirements
Module: vga_dac_ctrl

---
 rtl/vga_dac_pkg.sv | 26 ++
 rtl/vga_timing.sv | 67 ++++++
 rtl/vga_dac_ctrl.sv | 165 ++++++++++++++++
 tb/tb_vga_dac_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/vga_dac_pkg.sv
// Shared definitions for the VGA R2R DAC controller: pattern mode encoding,
// default 640x480 timing and a counter-width helper.
package vga_dac_pkg;

   typedef enum logic [1:0] {
      BARS  = 2'd0,
      GRAD  = 2'd1,
      CHECK = 2'd2,
      SOLID = 2'd3
   } mode_e;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   // Bits needed to hold 0..total-1, never less than one.
   function automatic int cnt_width(input int total);
      return (total > 1) ? $clog2(total) : 1;
   endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical pixel counters with wrap logic and the raw (active-high)
// sync and blank region decode; polarity and output registering are done by the top.
module vga_timing #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int HW       = 10,
   parameter int VW       = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ena,
   output logic [HW-1:0] h,
   output logic [VW-1:0] v,
   output logic          hblank_c,
   output logic          vblank_c,
   output logic          hsync_c,
   output logic          vsync_c,
   output logic          frame_start,
   output logic          frame_end
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_BEG  = H_ACTIVE + H_FP;
   localparam int HS_END  = HS_BEG + H_SYNC;
   localparam int VS_BEG  = V_ACTIVE + V_FP;
   localparam int VS_END  = VS_BEG + V_SYNC;

   logic [31:0] h_w;
   logic [31:0] v_w;
   logic        h_last;
   logic        v_last;

   // Compare in 32 bits so bounds equal to 2**HW never truncate.
   assign h_w    = 32'(h);
   assign v_w    = 32'(v);
   assign h_last = (h_w == 32'(H_TOTAL - 1));
   assign v_last = (v_w == 32'(V_TOTAL - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h <= '0;
         v <= '0;
      end else if (ena) begin
         if (h_last) begin
            h <= '0;
            v <= v_last ? '0 : v + VW'(1);
         end else begin
            h <= h + HW'(1);
         end
      end
   end

   assign hblank_c    = (h_w >= 32'(H_ACTIVE));
   assign vblank_c    = (v_w >= 32'(V_ACTIVE));
   assign hsync_c     = (h_w >= 32'(HS_BEG)) && (h_w < 32'(HS_END));
   assign vsync_c     = (v_w >= 32'(VS_BEG)) && (v_w < 32'(VS_END));
   assign frame_start = (h_w == 32'd0) && (v_w == 32'd0);
   assign frame_end   = h_last && v_last;

endmodule

// File: rtl/vga_dac_ctrl.sv
// VGA test-pattern generator driving three R2R DACs: pattern select, frame
// counter and the single output register stage that keeps all outputs aligned.
module vga_dac_ctrl
   import vga_dac_pkg::*;
#(
   parameter int BPC      = 8,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           ena,
   input  logic [1:0]     mode,
   input  logic           anim,
   output logic [BPC-1:0] r,
   output logic [BPC-1:0] g,
   output logic [BPC-1:0] b,
   output logic           hsync,
   output logic           vsync,
   output logic           hblank,
   output logic           vblank,
   output logic [7:0]     frame
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = cnt_width(H_TOTAL);
   localparam int VW      = cnt_width(V_TOTAL);
   localparam int BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
   localparam logic [BPC-1:0] HALF = {1'b1, {(BPC-1){1'b0}}};

   logic [HW-1:0]  h;
   logic [VW-1:0]  v;
   logic           hblank_c;
   logic           vblank_c;
   logic           hsync_c;
   logic           vsync_c;
   logic           frame_start;
   logic           frame_end;

   mode_e          mode_q;
   mode_e          mode_eff;
   logic [7:0]     frame_cnt;
   logic [31:0]    h_w;
   logic [31:0]    v_w;
   logic [2:0]     bar_k;
   logic [BPC-1:0] pat_r;
   logic [BPC-1:0] pat_g;
   logic [BPC-1:0] pat_b;

   vga_timing #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP),
      .HW       (HW),
      .VW       (VW)
   ) u_timing (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .h           (h),
      .v           (v),
      .hblank_c    (hblank_c),
      .vblank_c    (vblank_c),
      .hsync_c     (hsync_c),
      .vsync_c     (vsync_c),
      .frame_start (frame_start),
      .frame_end   (frame_end)
   );

   // A request present on the frame-start cycle already drives pixel (0,0).
   assign mode_eff = frame_start ? mode_e'(mode) : mode_q;
   assign h_w      = 32'(h);
   assign v_w      = 32'(v);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q    <= BARS;
         frame_cnt <= 8'd0;
      end else if (ena) begin
         if (frame_start) mode_q <= mode_e'(mode);
         if (frame_end && anim) frame_cnt <= frame_cnt + 8'd1;
      end
   end

   always_comb begin
      pat_r = '0;
      pat_g = '0;
      pat_b = '0;
      bar_k = 3'(h_w / 32'(BAR_W));
      case (mode_eff)
         BARS: begin
            pat_r = {BPC{bar_k[2]}};
            pat_g = {BPC{bar_k[1]}};
            pat_b = {BPC{bar_k[0]}};
         end
         GRAD: begin
            pat_r = BPC'(h_w + 32'(frame_cnt));
            pat_g = BPC'(v_w);
            pat_b = pat_r ^ pat_g;
         end
         CHECK: begin
            pat_r = {BPC{h_w[5] ^ v_w[5]}};
            pat_g = {BPC{h_w[5] ^ v_w[5]}};
            pat_b = {BPC{h_w[5] ^ v_w[5]}};
         end
         SOLID: begin
            pat_r = HALF;
            pat_g = HALF;
            pat_b = HALF;
         end
         default: ;
      endcase
      if (hblank_c || vblank_c) begin
         pat_r = '0;
         pat_g = '0;
         pat_b = '0;
      end
   end

   // Paused cycles present the same idle picture as reset while frame holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r      <= '0;
         g      <= '0;
         b      <= '0;
         hsync  <= ~SYNC_POL;
         vsync  <= ~SYNC_POL;
         hblank <= 1'b1;
         vblank <= 1'b1;
         frame  <= 8'd0;
      end else if (ena) begin
         r      <= pat_r;
         g      <= pat_g;
         b      <= pat_b;
         hsync  <= hsync_c ? SYNC_POL : ~SYNC_POL;
         vsync  <= vsync_c ? SYNC_POL : ~SYNC_POL;
         hblank <= hblank_c;
         vblank <= vblank_c;
         frame  <= frame_cnt;
      end else begin
         r      <= '0;
         g      <= '0;
         b      <= '0;
         hsync  <= ~SYNC_POL;
         vsync  <= ~SYNC_POL;
         hblank <= 1'b1;
         vblank <= 1'b1;
         frame  <= frame_cnt;
      end
   end

endmodule

// File: tb/tb_vga_dac_ctrl.sv
// Directed bench for vga_dac_ctrl on a shrunken 44x6 raster so sync, pattern,
// mode-sampling, pause, reset and 256-frame wrap behaviour all fit in a short run.
module tb_vga_dac_ctrl;

   localparam int BPC = 8;
   localparam int HA = 40, HF = 1, HS = 2, HB = 1;
   localparam int VA = 3,  VF = 1, VS = 1, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           ena = 1'b1;
   logic [1:0]     mode = 2'd0;
   logic           anim = 1'b0;
   logic [BPC-1:0] r, g, b;
   logic           hsync, vsync, hblank, vblank;
   logic [7:0]     frame;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   vga_dac_ctrl #(
      .BPC (BPC), .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB), .SYNC_POL (1'b0)
   ) dut (
      .clk (clk), .rst_n (rst_n), .ena (ena), .mode (mode), .anim (anim),
      .r (r), .g (g), .b (b), .hsync (hsync), .vsync (vsync),
      .hblank (hblank), .vblank (vblank), .frame (frame)
   );

   // clock / reset block; cyc counts pixel-clock edges that advanced the raster
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else if (ena) cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Advance until the outputs show raster pixel (th, tv); outputs lag by one edge.
   task automatic goto_pixel(input int th, input int tv);
      int n;
      n = 0;
      @(negedge clk);
      while (!(((cyc - 1) % HT == th) && (((cyc - 1) / HT) % VT == tv)) && n < 2 * FT) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2 * FT) check("goto_timeout", n, 0);
   endtask

   task automatic check_rgb(input string tag, input int er, input int eg, input int eb);
      check({tag, "_r"}, r, er);
      check({tag, "_g"}, g, eg);
      check({tag, "_b"}, b, eb);
   endtask

   task automatic check_idle(input string tag);
      check_rgb(tag, 0, 0, 0);
      check({tag, "_hs"}, hsync, 1);
      check({tag, "_vs"}, vsync, 1);
      check({tag, "_hbl"}, hblank, 1);
      check({tag, "_vbl"}, vblank, 1);
   endtask

   // Edges from reset release until hsync first reads low.
   task automatic edges_to_hsync(output int n);
      n = 0;
      while (hsync !== 1'b0 && n < 4 * HT) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      int n, w, p, cnt;

      repeat (3) @(negedge clk);
      check_idle("reset");
      check("reset_frame", frame, 0);

      // horizontal sync: onset, width, period; hblank duty
      rst_n = 1'b1;
      edges_to_hsync(n);
      check("hs_onset", n, HA + HF + 1);
      w = 0;
      while (hsync === 1'b0 && w < 4 * HT) begin @(negedge clk); w++; end
      check("hs_width", w, HS);
      p = 0;
      while (hsync !== 1'b0 && p < 4 * HT) begin @(negedge clk); p++; end
      check("hs_period", w + p, HT);
      cnt = 0;
      for (int i = 0; i < HT; i++) begin
         if (hblank === 1'b1) cnt++;
         @(negedge clk);
      end
      check("hblank_duty", cnt, HT - HA);

      // vertical sync: starting line, width, period
      n = 0;
      while (vsync !== 1'b0 && n < 2 * FT) begin @(negedge clk); n++; end
      check("vs_start", (cyc - 1) % FT, (VA + VF) * HT);
      w = 0;
      while (vsync === 1'b0 && w < 2 * FT) begin @(negedge clk); w++; end
      check("vs_width", w, VS * HT);
      p = 0;
      while (vsync !== 1'b0 && p < 2 * FT) begin @(negedge clk); p++; end
      check("vs_period", w + p, FT);

      // colour bars, bar width 5
      goto_pixel(0, 0);  check_rgb("bar_h0", 0, 0, 0);
      goto_pixel(5, 0);  check_rgb("bar_h5", 0, 0, 255);
      goto_pixel(10, 0); check_rgb("bar_h10", 0, 255, 0);
      goto_pixel(20, 0); check_rgb("bar_h20", 255, 0, 0);
      goto_pixel(35, 0); check_rgb("bar_h35", 255, 255, 255);
      check("bar_hbl_active", hblank, 0);
      goto_pixel(41, 0); check_rgb("bar_h41", 0, 0, 0);
      check("bar_hbl_blank", hblank, 1);
      goto_pixel(10, 4); check_rgb("bar_vblank", 0, 0, 0);
      check("bar_vbl", vblank, 1);

      // mid-frame mode request waits for the next frame
      goto_pixel(0, 1);  mode = 2'd2;
      goto_pixel(5, 2);  check_rgb("late_bars", 0, 0, 255);
      goto_pixel(32, 0); check_rgb("chk_h32", 255, 255, 255);
      goto_pixel(5, 0);  check_rgb("chk_h5", 0, 0, 0);

      // request on the frame-start cycle is used immediately; one cycle later is not
      goto_pixel(HT - 1, VT - 1); mode = 2'd3;
      goto_pixel(0, 0);  check_rgb("solid_00", 128, 128, 128);
      mode = 2'd0;
      goto_pixel(5, 0);  check_rgb("solid_50", 128, 128, 128);

      // pause and resume from the held position
      goto_pixel(20, 1); check_rgb("pre_pause", 128, 128, 128);
      ena = 1'b0;
      @(negedge clk);
      check_idle("pause");
      repeat (5) @(negedge clk);
      check("pause_r", r, 0);
      ena = 1'b1;
      @(negedge clk);
      check("resume_pos", (cyc - 1) % FT, HT + 21);
      check("resume_r", r, 128);
      check("resume_hbl", hblank, 0);
      goto_pixel(5, 0);  check_rgb("bars_again", 0, 0, 255);

      // asynchronous reset mid-frame, then fresh hsync timing
      goto_pixel(30, 2); check_rgb("pre_reset", 255, 255, 0);
      #2 rst_n = 1'b0;
      #1 check_idle("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      edges_to_hsync(n);
      check("hs_after_reset", n, HA + HF + 1);

      // gradient with animation, hold, and 8-bit frame wrap
      rst_n = 1'b0;
      mode = 2'd1;
      anim = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      goto_pixel(0, 0);  check("grad_f0", frame, 0);
      goto_pixel(10, 2); check_rgb("grad_10_2", 10, 2, 8);
      goto_pixel(0, 0);  check("grad_f1", frame, 1);
      check_rgb("grad_f1_00", 1, 0, 1);
      anim = 1'b0;
      goto_pixel(0, 0);  check("anim_hold", frame, 1);
      anim = 1'b1;
      for (int i = 0; i < 254; i++) goto_pixel(0, 0);
      check("frame_255", frame, 255);
      goto_pixel(3, 1);  check_rgb("grad_f255", 2, 1, 3);
      goto_pixel(0, 0);  check("frame_wrap", frame, 0);
      check("grad_wrap_r", r, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
